// File: rtl/seg_pkg.sv
// Shared types and seven-segment glyph constants for the segment-bus capture block.
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    // segs[6:0] = g..a, active-high
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h67;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_capture_if.sv
// Segment bus in, captured frame out. The slave side is the capture block.
interface seg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_pkg::*;

    seg_t                      segs;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [4*NUM_DIGITS-1:0]   data;
    logic [NUM_DIGITS-1:0]     err;
    logic                      out_valid;
    logic                      out_ready;
    logic                      overrun;

    // A word transfers on a rising edge where out_valid and out_ready are both
    // high; once raised, out_valid and data/err hold until that edge, and
    // out_ready has no effect while out_valid is low.
    modport slave (
        input  segs, digit_en, out_ready,
        output data, err, out_valid, overrun
    );

    modport master (
        output segs, digit_en, out_ready,
        input  data, err, out_valid, overrun
    );

endinterface

// File: rtl/seg_decode.sv
// Glyph-to-nibble decoder; unknown patterns (blank included) report invalid.
module seg_decode
    import seg_pkg::*;
(
    input  seg_t    segs,
    output nibble_t nibble,
    output logic    invalid
);

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (segs)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Recovers the word shown on a multiplexed seven-segment display, one word per
// complete frame, after each digit has been stable for STABLE_CYCLES samples.
module seg_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_capture_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0] prev_en_q, prev_en_d;
    seg_t                  prev_segs_q, prev_segs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] sherr_q, sherr_d;
    logic [DW-1:0]         data_q, data_d;
    logic [NUM_DIGITS-1:0] err_q, err_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic          one_hot;
    logic          same;
    logic          capture;
    logic [IW-1:0] idx;
    nibble_t       dec_nibble;
    logic          dec_invalid;

    seg_decode u_decode (
        .segs    (bus.segs),
        .nibble  (dec_nibble),
        .invalid (dec_invalid)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.digit_en[i]) idx = IW'(i);
        end
    end

    always_comb begin
        prev_en_d   = bus.digit_en;
        prev_segs_d = bus.segs;
        one_hot     = ($countones(bus.digit_en) == 1);
        same        = (bus.digit_en == prev_en_q) && (bus.segs == prev_segs_q);

        if (!one_hot)               cnt_d = '0;
        else if (!same)             cnt_d = CW'(1);
        else if (cnt_q < CNT_MAX)   cnt_d = cnt_q + CW'(1);
        else                        cnt_d = cnt_q;

        // Fire only on arrival at the limit; a changed sample also counts as
        // arrival when the limit is 1 and the counter was already saturated.
        capture = one_hot && (cnt_d == CNT_MAX) && (!same || (cnt_q != CNT_MAX));

        shadow_d  = shadow_q;
        sherr_d   = sherr_q;
        mask_d    = mask_q;
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && bus.out_ready) valid_d = 1'b0;

        if (capture) begin
            shadow_d[4*idx +: 4] = dec_nibble;
            sherr_d[idx]         = dec_invalid;
            mask_d[idx]          = 1'b1;
            if (&mask_d) begin
                mask_d = '0;
                if (!valid_q || bus.out_ready) begin
                    data_d  = shadow_d;
                    err_d   = sherr_d;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_en_q   <= '0;
            prev_segs_q <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            shadow_q    <= '0;
            sherr_q     <= '0;
            data_q      <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_en_q   <= prev_en_d;
            prev_segs_q <= prev_segs_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            sherr_q     <= sherr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.err       = err_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: a table of full frames plus hand-written
// sequences for backpressure, illegal strobes and mid-frame reset.
module tb_seg_capture;
    import seg_pkg::*;

    logic clk;
    logic rst_n;

    seg_capture_if #(.NUM_DIGITS(4)) bus ();

    seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int valid_seen   = 0;
    int overrun_seen = 0;

    always @(posedge clk) begin
        if (bus.out_valid) valid_seen++;
        if (bus.overrun)   overrun_seen++;
    end

    typedef struct {
        logic [3:0][6:0] glyph;      // glyph[d] shown on digit d
        int              pre_dig;    // digit preceded by a short glitch run
        seg_t            pre_seg;
        int              pre_cyc;
        logic [15:0]     exp_data;
        logic [3:0]      exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_raw(input logic [3:0] en, input seg_t s, input int n);
        @(negedge clk);
        bus.digit_en = en;
        bus.segs     = s;
        repeat (n) @(posedge clk);
    endtask

    task automatic show(input int dig, input seg_t s, input int n);
        drive_raw(4'(1 << dig), s, n);
    endtask

    initial begin
        int v0;
        int o0;

        vecs[0] = '{glyph: {SEG_4, SEG_3, SEG_2, SEG_1}, pre_dig: 0, pre_seg: SEG_BLANK, pre_cyc: 0,
                    exp_data: 16'h4321, exp_err: 4'b0000};
        vecs[1] = '{glyph: {SEG_0, SEG_0, SEG_1, SEG_0}, pre_dig: 1, pre_seg: SEG_8, pre_cyc: 3,
                    exp_data: 16'h0010, exp_err: 4'b0000};
        vecs[2] = '{glyph: {SEG_0, 7'h01, SEG_0, SEG_0}, pre_dig: 0, pre_seg: SEG_BLANK, pre_cyc: 0,
                    exp_data: 16'h0000, exp_err: 4'b0100};
        vecs[3] = '{glyph: {SEG_D, SEG_C, SEG_B, SEG_A}, pre_dig: 0, pre_seg: SEG_BLANK, pre_cyc: 0,
                    exp_data: 16'hDCBA, exp_err: 4'b0000};
        vecs[4] = '{glyph: {SEG_9, SEG_8, SEG_F, SEG_E}, pre_dig: 2, pre_seg: SEG_2, pre_cyc: 2,
                    exp_data: 16'h98FE, exp_err: 4'b0000};
        vecs[5] = '{glyph: {SEG_7, SEG_6, SEG_5, SEG_BLANK}, pre_dig: 0, pre_seg: SEG_BLANK, pre_cyc: 0,
                    exp_data: 16'h7650, exp_err: 4'b0001};

        rst_n         = 1'b0;
        bus.digit_en  = '0;
        bus.segs      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset data", 32'(bus.data), 32'h0);
        chk("reset err", 32'(bus.err), 32'h0);
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset overrun", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            v0 = valid_seen;
            for (int d = 0; d < 4; d++) begin
                if (vecs[i].pre_cyc > 0 && vecs[i].pre_dig == d)
                    show(d, vecs[i].pre_seg, vecs[i].pre_cyc);
                show(d, vecs[i].glyph[d], 4);
            end
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("v%0d data", i), 32'(bus.data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d err", i), 32'(bus.err), 32'(vecs[i].exp_err));
            drive_raw(4'b0000, SEG_BLANK, 1);
            @(negedge clk);
            chk($sformatf("v%0d valid drop", i), 32'(bus.out_valid), 32'h0);
            chk($sformatf("v%0d valid pulses", i), 32'(valid_seen - v0), 32'h1);
        end

        // Illegal strobes must never set mask bits.
        v0 = valid_seen;
        drive_raw(4'b0011, SEG_0, 20);
        drive_raw(4'b0000, SEG_0, 20);
        show(2, SEG_C, 4);
        show(3, SEG_D, 4);
        @(negedge clk);
        chk("illegal no valid", 32'(valid_seen - v0), 32'h0);
        chk("illegal out_valid", 32'(bus.out_valid), 32'h0);
        show(0, SEG_A, 4);
        show(1, SEG_B, 4);
        @(negedge clk);
        chk("illegal then frame valid", 32'(bus.out_valid), 32'h1);
        chk("illegal then frame data", 32'(bus.data), 32'hDCBA);
        drive_raw(4'b0000, SEG_BLANK, 1);

        // Backpressure: second frame is dropped while the first is held.
        @(negedge clk);
        bus.out_ready = 1'b0;
        o0 = overrun_seen;
        show(0, SEG_F, 4);
        show(1, SEG_E, 4);
        show(2, SEG_E, 4);
        show(3, SEG_B, 4);
        @(negedge clk);
        chk("bp frame A valid", 32'(bus.out_valid), 32'h1);
        chk("bp frame A data", 32'(bus.data), 32'hBEEF);
        show(0, SEG_4, 4);
        show(1, SEG_3, 4);
        show(2, SEG_2, 4);
        show(3, SEG_1, 4);
        @(negedge clk);
        chk("bp overrun pulse", 32'(bus.overrun), 32'h1);
        chk("bp data held", 32'(bus.data), 32'hBEEF);
        chk("bp valid held", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        chk("bp overrun clear", 32'(bus.overrun), 32'h0);
        chk("bp overrun count", 32'(overrun_seen - o0), 32'h1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp accept drops valid", 32'(bus.out_valid), 32'h0);
        chk("bp data after accept", 32'(bus.data), 32'hBEEF);
        drive_raw(4'b0000, SEG_BLANK, 1);

        // Reset mid-frame discards partial captures.
        show(0, SEG_1, 4);
        show(1, SEG_2, 4);
        show(2, SEG_3, 4);
        @(negedge clk);
        bus.digit_en = '0;
        bus.segs     = '0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst data", 32'(bus.data), 32'h0);
        chk("midrst err", 32'(bus.err), 32'h0);
        chk("midrst out_valid", 32'(bus.out_valid), 32'h0);
        v0 = valid_seen;
        show(3, SEG_9, 4);
        @(negedge clk);
        chk("midrst partial no valid", 32'(valid_seen - v0), 32'h0);
        chk("midrst partial out_valid", 32'(bus.out_valid), 32'h0);
        show(0, SEG_5, 4);
        show(1, SEG_6, 4);
        show(2, SEG_7, 4);
        @(negedge clk);
        chk("midrst frame valid", 32'(bus.out_valid), 32'h1);
        chk("midrst frame data", 32'(bus.data), 32'h9765);
        drive_raw(4'b0000, SEG_BLANK, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive side of the seven-segment display interface: samples a multiplexed segment bus (7 segment lines plus one-hot digit enables) and recovers the hex nibble shown on each digit.
- Assembles one NUM_DIGITS-nibble word per complete display frame and presents it on a valid/ready output.
- Used on the FPGA board and in benches to self-check the displayed register value against the cpu16 core state.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; output word width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4, consecutive identical cycles of (digit_en, segs) required before a capture; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- segs  input  7  segment lines, active-high, bit0=a .. bit6=g
- digit_en  input  NUM_DIGITS  digit strobes, active-high, expected one-hot
- data  output  4*NUM_DIGITS  captured word; digit i occupies bits [4i+3:4i]
- err  output  NUM_DIGITS  per-digit flag: captured pattern was not a legal hex glyph
- out_valid  output  1  data/err hold a complete frame
- out_ready  input  1  consumer accepts data when high together with out_valid
- overrun  output  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset (rst_n low at a rising edge): data=0, err=0, out_valid=0, overrun=0. Frame mask, shadow nibbles, stability counter and previous-sample registers are also cleared. Reset mid-frame discards all partial captures.
- Registers prev_en/prev_segs are loaded with the inputs every cycle.
- Stability counter:
  - If digit_en is not one-hot (zero or multiple bits set), or (digit_en, segs) differs from the previous cycle, the counter loads 1 (0 if not one-hot).
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- Capture:
  - Occurs on the cycle the counter reaches STABLE_CYCLES, i.e. after STABLE_CYCLES consecutive identical samples. It occurs once per stable run, with no repeat while the counter stays saturated.
  - The capture writes the decoded nibble and error bit into the shadow slot of the enabled digit and sets that digit's frame-mask bit.
  - Re-capturing an already-masked digit overwrites its slot; latest value wins.
- Decode: the 16 legal glyphs are 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71 (hex, segs[6:0]). Any other pattern, including blank 00, gives nibble 0 with err bit 1.
- Frame completion: evaluated in the same cycle the capture makes the mask all ones.
  - If out_valid=0, or out_valid=1 and out_ready=1 in that cycle, the shadow is loaded into data/err, out_valid=1 next cycle, and the mask is cleared.
  - Otherwise the frame is dropped: the mask is cleared, data/err are unchanged, and overrun=1 for exactly one cycle.
- Handshake:
  - out_valid stays high and data/err stay stable until out_ready is sampled high.
  - When out_valid=1 and out_ready=1 with no simultaneous frame completion, out_valid=0 next cycle.
  - out_ready while out_valid=0 is ignored.
- Latency: last input change at cycle t leads to capture at edge t+STABLE_CYCLES-1. A frame-completing capture makes out_valid high one cycle later.
- Width rules: the counter is clog2(STABLE_CYCLES+1) bits. The one-hot check is popcount==1. The digit index is the one-hot-to-binary encode of digit_en.

Decomposition:
- Shared package seg_pkg holds:
  - the glyph constants (SEG_0..SEG_F, SEG_BLANK)
  - typedef seg_t (logic [6:0])
  - typedef nibble_t (logic [3:0])
- Sub-module seg_decode: purely combinational, segs -> {nibble, invalid}, built from the seg_pkg constants.
- The top level holds the counter, mask, shadow registers and the output stage.

Test Plan:
- Frame capture: digits 0..3 show 1,2,3,4 (06,5B,4F,66), 4 cycles each, out_ready=1 -> out_valid pulses once, data=16'h4321, err=0.
- Glitch rejection: digit 1 shows 7F for 3 cycles then 06 for 4 cycles, with the other digits showing 0 -> data[7:4]=1, and no capture of 8 ever occurs.
- Invalid glyph: digit 2 shows 01, the others show 3F -> data=16'h0000, err=4'b0100.
- Backpressure: out_ready=0, frame A=16'hBEEF completes, then frame B completes -> overrun pulses for 1 cycle, data stays 16'hBEEF. Raising out_ready -> out_valid=0 next cycle.
- Illegal strobes: digit_en=4'b0011 or 4'b0000 held for 20 cycles with segs=3F -> no mask change, no out_valid.
- Reset mid-frame: 3 digits captured, then rst_n=0 for 1 cycle -> all outputs 0. A full 4-digit frame is required again before out_valid.
